id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core. Captures operands read from the
//  register file (RD1/RD2), the extended immediate and decode control at the end of D,
//  and presents them to E. Supports freeze (hold), bubble insertion (stall/flush),
//  write-back refresh of held operands, and a saturating bubble counter.
// PARAMETERS
//  RESET_PC   32'h0000_3000  value of E_PC after reset
//  TNEW_W     2              width of the Tnew field
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous active-high reset
//  hold         in   1   freeze whole register (e.g. MD unit busy in E)
//  stall        in   1   D-stage hazard stall: load a bubble into E
//  flush        in   1   squash D instruction: load a bubble into E
//  D_valid      in   1   D holds a real instruction
//  D_PC         in   32  PC of D instruction
//  D_instr      in   32  instruction word
//  D_RD1        in   32  rs operand (already D-forwarded)
//  D_RD2        in   32  rt operand (already D-forwarded)
//  D_imm32      in   32  extended immediate
//  D_A3         in   5   destination register
//  D_RegWrite   in   1   instruction writes GRF
//  D_Tnew       in   TNEW_W  cycles until result ready, measured from E
//  W_RegWrite   in   1   W-stage GRF write enable
//  W_A3         in   5   W-stage destination
//  W_WD         in   32  W-stage write data
//  E_valid, E_PC, E_instr, E_RD1, E_RD2, E_imm32, E_A3, E_RegWrite, E_Tnew
//               out  (widths as D_*)  registered copies presented to E
//  bubble_cnt   out  32  count of bubbles inserted since reset
// BEHAVIOUR
//  - All outputs registered; 1-cycle latency D_* -> E_*.
//  - Reset: E_PC=RESET_PC, all other E_* = 0 (E_instr=0 is nop), bubble_cnt=0.
//  - Per-edge priority: reset > hold > (stall|flush) > load.
//  - hold=1: every E_* keeps its value, except refresh (below); stall/flush ignored,
//    bubble_cnt unchanged.
//  - Refresh during hold: if W_RegWrite && W_A3!=0 && W_A3==E_instr[25:21] then
//    E_RD1<=W_WD; likewise W_A3==E_instr[20:16] -> E_RD2<=W_WD. Both may fire in one
//    cycle. Not applied when E_valid=0. Reg 0 never refreshed.
//  - Bubble (stall|flush, hold=0): E_PC<=D_PC (kept for exception PC), all other
//    E_* <= 0, E_valid<=0; bubble_cnt<=bubble_cnt+1, saturating at 32'hFFFF_FFFF.
//    stall and flush together count as one bubble.
//  - Load (no hold/stall/flush): E_*<=D_*; E_valid<=D_valid; if D_valid=0 then
//    E_RegWrite and E_Tnew forced 0 and E_A3 forced 0 (no false hazards).
//  - E_A3=0 always implies E_RegWrite is ignored downstream; block still passes it.
//  - E_Tnew stored unmodified; decrement is the E/M register's job.
//  - Reset asserted mid-hold or mid-stall clears immediately on that edge.
// TESTING
//  1 reset=1 one edge -> E_PC=32'h3000, E_instr=0, E_valid=0, bubble_cnt=0.
//  2 load D_PC=32'h3004, D_instr=32'h0043_0821, D_RD1=5, D_RD2=7, D_A3=1, D_RegWrite=1,
//    D_Tnew=1 -> next edge E_* equal; E_valid=1.
//  3 stall=1 for 3 edges with D_PC=32'h3008 -> E_PC=32'h3008, E_instr=0, E_RegWrite=0,
//    bubble_cnt=3; stall&flush both 1 one edge -> bubble_cnt=4.
//  4 hold=1 with E_instr rs=2, rt=3; W_RegWrite=1,W_A3=2,W_WD=32'hDEAD_BEEF ->
//    E_RD1=32'hDEADBEEF, E_RD2 unchanged, E_PC unchanged; W_A3=0 -> no change.
//  5 hold=1 and stall=1 together -> no bubble, bubble_cnt unchanged, E_instr kept.
//  6 force bubble_cnt to 32'hFFFF_FFFF (long stall or force) then stall -> stays
//    32'hFFFF_FFFF; D_valid=0 load with D_RegWrite=1,D_A3=9 -> E_RegWrite=0,E_A3=0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register of the 5-stage MIPS core. Captures the decoded
//   instruction, its register-file operands and extended immediate at the end
//   of D and presents them to E one cycle later.
//
//   Per-edge priority: reset > hold > bubble (stall|flush) > load.
//     hold   : freeze every E_* field; held operands may be refreshed by the
//              W-stage write so a long-running E instruction never consumes
//              stale data.
//     bubble : E receives a nop but keeps D_PC (exception PC); bubble_cnt
//              counts inserted bubbles, saturating at all-ones.
//     load   : E_* <= D_*; an invalid D slot never advertises a destination.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   hold, stall, flush  pipeline control from the hazard unit
//   D_*                 decode-stage instruction fields (inputs)
//   W_RegWrite/A3/WD    write-back port, used for refresh while holding
//   E_*                 registered copies presented to the execute stage
//   bubble_cnt          bubbles inserted since reset (saturating)
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              stall,
  input  logic              flush,
  input  logic              D_valid,
  input  logic [31:0]       D_PC,
  input  logic [31:0]       D_instr,
  input  logic [31:0]       D_RD1,
  input  logic [31:0]       D_RD2,
  input  logic [31:0]       D_imm32,
  input  logic [4:0]        D_A3,
  input  logic              D_RegWrite,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              W_RegWrite,
  input  logic [4:0]        W_A3,
  input  logic [31:0]       W_WD,
  output logic              E_valid,
  output logic [31:0]       E_PC,
  output logic [31:0]       E_instr,
  output logic [31:0]       E_RD1,
  output logic [31:0]       E_RD2,
  output logic [31:0]       E_imm32,
  output logic [4:0]        E_A3,
  output logic              E_RegWrite,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [31:0]       bubble_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic bubble;
  logic w_live;
  logic refresh_rs;
  logic refresh_rt;

  // Refresh only applies to a real held instruction; register 0 is hardwired.
  assign bubble     = stall | flush;
  assign w_live     = E_valid & W_RegWrite & (W_A3 != 5'd0);
  assign refresh_rs = w_live & (W_A3 == E_instr[25:21]);
  assign refresh_rt = w_live & (W_A3 == E_instr[20:16]);

  // ---- D -> E boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      E_valid    <= 1'b0;
      E_PC       <= RESET_PC;
      E_instr    <= '0;
      E_RD1      <= '0;
      E_RD2      <= '0;
      E_imm32    <= '0;
      E_A3       <= '0;
      E_RegWrite <= 1'b0;
      E_Tnew     <= '0;
      bubble_cnt <= '0;
    end else if (hold) begin
      if (refresh_rs) E_RD1 <= W_WD;
      if (refresh_rt) E_RD2 <= W_WD;
    end else if (bubble) begin
      // PC survives the bubble so a later exception can still report it.
      E_valid    <= 1'b0;
      E_PC       <= D_PC;
      E_instr    <= '0;
      E_RD1      <= '0;
      E_RD2      <= '0;
      E_imm32    <= '0;
      E_A3       <= '0;
      E_RegWrite <= 1'b0;
      E_Tnew     <= '0;
      bubble_cnt <= sat_inc(bubble_cnt);
    end else begin
      E_valid    <= D_valid;
      E_PC       <= D_PC;
      E_instr    <= D_instr;
      E_RD1      <= D_RD1;
      E_RD2      <= D_RD2;
      E_imm32    <= D_imm32;
      // An empty slot must not look like a producer to the hazard unit.
      E_A3       <= D_valid ? D_A3       : 5'd0;
      E_RegWrite <= D_valid ? D_RegWrite : 1'b0;
      E_Tnew     <= D_valid ? D_Tnew     : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, hold, stall, flush, D_valid, D_RegWrite, W_RegWrite;
  logic [31:0] D_PC, D_instr, D_RD1, D_RD2, D_imm32, W_WD;
  logic [4:0]  D_A3, W_A3;
  logic [1:0]  D_Tnew;
  logic        E_valid, E_RegWrite;
  logic [31:0] E_PC, E_instr, E_RD1, E_RD2, E_imm32, bubble_cnt;
  logic [4:0]  E_A3;
  logic [1:0]  E_Tnew;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.RESET_PC(32'h0000_3000), .TNEW_W(2)) dut (
    .clk(clk), .reset(reset), .hold(hold), .stall(stall), .flush(flush),
    .D_valid(D_valid), .D_PC(D_PC), .D_instr(D_instr), .D_RD1(D_RD1),
    .D_RD2(D_RD2), .D_imm32(D_imm32), .D_A3(D_A3), .D_RegWrite(D_RegWrite),
    .D_Tnew(D_Tnew), .W_RegWrite(W_RegWrite), .W_A3(W_A3), .W_WD(W_WD),
    .E_valid(E_valid), .E_PC(E_PC), .E_instr(E_instr), .E_RD1(E_RD1),
    .E_RD2(E_RD2), .E_imm32(E_imm32), .E_A3(E_A3), .E_RegWrite(E_RegWrite),
    .E_Tnew(E_Tnew), .bubble_cnt(bubble_cnt)
  );

  // Reference model: the E-stage contents as a set of plain variables,
  // updated from the rules once per clock edge.
  logic        m_valid, m_rw;
  logic [31:0] m_pc, m_instr, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_a3;
  logic [1:0]  m_tnew;
  longint      m_cnt;

  task automatic model_clear(input logic [31:0] pc);
    m_valid = 0; m_pc = pc; m_instr = 0; m_rd1 = 0; m_rd2 = 0;
    m_imm = 0; m_a3 = 0; m_rw = 0; m_tnew = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear(32'h0000_3000);
      m_cnt = 0;
    end else if (hold) begin
      if (m_valid && W_RegWrite && W_A3 != 0) begin
        if (W_A3 == m_instr[25:21]) m_rd1 = W_WD;
        if (W_A3 == m_instr[20:16]) m_rd2 = W_WD;
      end
    end else if (stall || flush) begin
      model_clear(D_PC);
      m_cnt = (m_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
    end else begin
      m_valid = D_valid; m_pc = D_PC; m_instr = D_instr;
      m_rd1 = D_RD1; m_rd2 = D_RD2; m_imm = D_imm32;
      m_a3   = D_valid ? D_A3 : 5'd0;
      m_rw   = D_valid ? D_RegWrite : 1'b0;
      m_tnew = D_valid ? D_Tnew : 2'd0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".E_valid"},    {31'd0, E_valid},    {31'd0, m_valid});
    check({ctx, ".E_PC"},       E_PC,                m_pc);
    check({ctx, ".E_instr"},    E_instr,             m_instr);
    check({ctx, ".E_RD1"},      E_RD1,               m_rd1);
    check({ctx, ".E_RD2"},      E_RD2,               m_rd2);
    check({ctx, ".E_imm32"},    E_imm32,             m_imm);
    check({ctx, ".E_A3"},       {27'd0, E_A3},       {27'd0, m_a3});
    check({ctx, ".E_RegWrite"}, {31'd0, E_RegWrite}, {31'd0, m_rw});
    check({ctx, ".E_Tnew"},     {30'd0, E_Tnew},     {30'd0, m_tnew});
    check({ctx, ".bubble_cnt"}, bubble_cnt,          m_cnt[31:0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; hold = 0; stall = 0; flush = 0;
    D_valid = 0; D_PC = 0; D_instr = 0; D_RD1 = 0; D_RD2 = 0; D_imm32 = 0;
    D_A3 = 0; D_RegWrite = 0; D_Tnew = 0;
    W_RegWrite = 0; W_A3 = 0; W_WD = 0;
  endtask

  task automatic load_add();
    D_valid = 1; D_PC = 32'h3004; D_instr = 32'h0043_0821;
    D_RD1 = 5; D_RD2 = 7; D_imm32 = 32'h0000_0821; D_A3 = 1;
    D_RegWrite = 1; D_Tnew = 1;
  endtask

  logic [4:0] rs_r, rt_r;

  initial begin
    idle_inputs();
    model_clear(32'h0);
    m_cnt = 0;

    // 1: reset
    reset = 1;
    step();
    reset = 0;
    check("rst.E_PC", E_PC, 32'h3000);
    check("rst.E_instr", E_instr, 32'h0);
    check("rst.E_valid", {31'd0, E_valid}, 32'd0);
    check("rst.bubble_cnt", bubble_cnt, 32'd0);

    // 2: plain load
    load_add();
    step();
    check_all("load");
    check("load.E_RD1", E_RD1, 32'd5);
    check("load.E_valid", {31'd0, E_valid}, 32'd1);

    // 3: three stalls then stall+flush
    stall = 1; D_PC = 32'h3008;
    repeat (3) step();
    check("stall.E_PC", E_PC, 32'h3008);
    check("stall.E_instr", E_instr, 32'h0);
    check("stall.E_RegWrite", {31'd0, E_RegWrite}, 32'd0);
    check("stall.bubble_cnt", bubble_cnt, 32'd3);
    flush = 1;
    step();
    check("stallflush.bubble_cnt", bubble_cnt, 32'd4);
    stall = 0; flush = 0;

    // 4: hold with W refresh of rs (rs=2, rt=3)
    load_add();
    step();
    hold = 1; D_valid = 0; D_PC = 32'h9999_0000;
    W_RegWrite = 1; W_A3 = 2; W_WD = 32'hDEAD_BEEF;
    step();
    check_all("refresh_rs");
    check("refresh.E_RD1", E_RD1, 32'hDEAD_BEEF);
    check("refresh.E_RD2", E_RD2, 32'd7);
    check("refresh.E_PC", E_PC, 32'h3004);
    W_A3 = 0; W_WD = 32'h1234_5678;
    step();
    check("refresh_r0.E_RD1", E_RD1, 32'hDEAD_BEEF);
    check("refresh_r0.E_RD2", E_RD2, 32'd7);
    W_A3 = 3; W_WD = 32'hCAFE_0003;
    step();
    check("refresh_rt.E_RD2", E_RD2, 32'hCAFE_0003);

    // 5: hold beats stall
    W_RegWrite = 0; stall = 1;
    step();
    check("holdstall.bubble_cnt", bubble_cnt, 32'd4);
    check("holdstall.E_instr", E_instr, 32'h0043_0821);
    check_all("holdstall");
    hold = 0;

    // 6: saturation; counter preset to all-ones across one stall edge
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF;
    step();
    release dut.bubble_cnt;
    step();
    check("sat.bubble_cnt", bubble_cnt, 32'hFFFF_FFFF);
    stall = 0;
    D_valid = 0; D_RegWrite = 1; D_A3 = 9; D_Tnew = 2; D_PC = 32'h300C;
    step();
    check("invalid.E_RegWrite", {31'd0, E_RegWrite}, 32'd0);
    check("invalid.E_A3", {27'd0, E_A3}, 32'd0);
    check_all("invalid");

    // Reset in the middle of a hold clears at once
    hold = 1; reset = 1;
    step();
    check("rsthold.bubble_cnt", bubble_cnt, 32'd0);
    check_all("rsthold");
    reset = 0; hold = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      D_valid = ($urandom_range(0, 4) != 0);
      D_PC = $urandom; D_RD1 = $urandom; D_RD2 = $urandom; D_imm32 = $urandom;
      rs_r = 5'($urandom_range(0, 3));
      rt_r = 5'($urandom_range(0, 3));
      D_instr = {6'($urandom), rs_r, rt_r, 16'($urandom)};
      D_A3 = 5'($urandom); D_RegWrite = 1'($urandom); D_Tnew = 2'($urandom);
      W_RegWrite = 1'($urandom); W_A3 = 5'($urandom_range(0, 3)); W_WD = $urandom;
      step();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
